indicator_decoder: RTL and testbench
====================================

Name: indicator_decoder

Overview:
- Receive side of the 4-digit multiplexed 7-segment bus driven by `indicator` (digits[3:0], segments[7:0]).
- Samples the scanned bus, waits for each digit strobe to settle, and decodes each segment pattern back to a hex nibble.
- Reassembles the 16-bit displayed value and pulses a frame flag once all four digits have been captured.
- Used as a loopback checker and self-test monitor beside `indicator` on the Laba4 board design.

Parameters:
- SETTLE_CYCLES, 4, consecutive identical synchronized samples required before a capture; legal range 1..255.
- DIGIT_ACTIVE_LOW, 1, 1 = a digit is selected when its digits bit is 0.
- SEG_ACTIVE_LOW, 1, 1 = a segment is lit when its segments bit is 0.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- digits  in  4  digit select lines from the display bus
- segments  in  8  segment lines; bit0=a … bit6=g, bit7=dp
- value  out  16  decoded nibbles; digit i maps to value[4i+3:4i]
- dp  out  4  captured decimal point per digit
- blank  out  4  digit i captured with no segments lit
- frame_valid  out  1  one-cycle pulse: all 4 digits captured since the last pulse
- err  out  1  sticky flag: an unrecognised segment pattern was captured

Behaviour:
- Reset (async, rst_n=0): value=0, dp=0, blank=0, frame_valid=0, err=0, seen mask=0, settle counter=0, FSM=WAIT, synchronizer flops=inactive level.
- Input path:
  - digits and segments each pass through a 2-flop synchronizer.
  - Polarity is normalised to active-high after the synchronizer.
- Select validity: a select is valid only when exactly one normalised digit bit is 1. Zero or multiple bits means blanking/ghosting: FSM returns to WAIT and the counter clears.
- FSM:
  - WAIT: on a valid select, load counter=1 and go to SETTLE.
  - SETTLE: if the (select, segments) pair equals the previous cycle's pair, increment the counter. Otherwise reload counter=1, staying in SETTLE if the select is valid and going to WAIT if not. When the counter reaches SETTLE_CYCLES, capture and go to HOLD.
  - HOLD: stay while the pair is unchanged. Any change goes to SETTLE (valid select) or WAIT (invalid select). This gives exactly one capture per select period.
- Capture, for digit i, registered on the capture cycle:
  - Write value nibble i and dp[i].
  - Set blank[i] = (segments[6:0]==0). On blank, the nibble is written as 0.
  - On an unrecognised non-blank pattern: set err, leave nibble i unchanged, do not set seen[i].
  - Otherwise set seen[i].
- Total latency from a bus change to the capture register update: 2 + SETTLE_CYCLES cycles.
- Frame:
  - When seen reaches 4'b1111, frame_valid is high for the next cycle and seen clears in that same cycle.
  - Recapturing an already-seen digit updates its nibble but leaves seen unchanged.
  - A capture that coincides with the seen clear is counted into the new seen mask.
- Decode table (gfedcba, active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- err clears only on reset.

Optional Feature:
- Macro: INDICATOR_DECODER_RAW_EN.
- Defined: adds output raw[31:0], holding the normalised segments byte captured for digit i in raw[8i+7:8i]. raw is written on every capture, including unrecognised patterns, and resets to 0.
- Undefined: the raw port and its registers do not exist; all other behaviour is identical.

Decomposition:
- Package indicator_pkg:
  - SEG_* pattern constants for 0–F and blank.
  - Segment bit index constants A..G, DP.
  - FSM state typedef {WAIT, SETTLE, HOLD}.
  - NUM_DIGITS=4.
- Sub-module seg7_to_hex: combinational, 7-bit pattern in; nibble, blank, and bad outputs. This is the inverse of the encoder table in `indicator`.

Test Plan:
- Reset: hold rst_n=0 with toggling inputs -> all outputs 0; release -> no capture for at least 2+SETTLE_CYCLES cycles.
- Scan "1234", active-low, 20 cycles per digit -> frame_valid pulses once per full scan; value=16'h1234 (digit3 = most significant nibble), dp=0, blank=0, err=0.
- Select glitches: digit changes after 2 cycles with SETTLE_CYCLES=4; also digits=4'b1100 (two selected) -> no capture, no frame_valid, value unchanged.
- Bad pattern: segments 7'h2A on digit 2 -> err=1 and stays 1; value nibble 2 unchanged; no frame_valid until digit 2 later shows a valid glyph.
- Blank and dp: digit 0 blank, digit 1 "A" with dp lit -> blank=4'b0001, nibble 1=A, dp[1]=1.
- Async reset mid-SETTLE: assert rst_n -> outputs clear immediately, without a clock edge; after release a full fresh scan is needed before frame_valid. With INDICATOR_DECODER_RAW_EN defined, raw matches the scanned bytes (e.g. 8'h5B for "2").

Source files
------------

// File: rtl/indicator_pkg.sv
// Shared definitions for the 7-segment bus decoder: glyph patterns,
// segment bit positions, FSM state encoding and digit-count helpers.
// Optional feature macro used elsewhere: INDICATOR_DECODER_RAW_EN.
package indicator_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    // Segment bit positions on the normalised segments byte
    localparam int unsigned BIT_A  = 0;
    localparam int unsigned BIT_B  = 1;
    localparam int unsigned BIT_C  = 2;
    localparam int unsigned BIT_D  = 3;
    localparam int unsigned BIT_E  = 4;
    localparam int unsigned BIT_F  = 5;
    localparam int unsigned BIT_G  = 6;
    localparam int unsigned BIT_DP = 7;

    // Active-high gfedcba glyph patterns, inverse of the indicator encoder
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Position of the set bit in a one-hot digit select
    function automatic logic [1:0] onehot_index(input logic [NUM_DIGITS-1:0] sel);
        onehot_index = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
                onehot_index = 2'(i);
            end
        end
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern to hex nibble decoder.
// blank: no segment lit; bad: lit pattern that is not a hex glyph.
// A blank or bad pattern yields nibble 0.
module seg7_to_hex
    import indicator_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       bad
);

    // Table lookup of the sixteen glyphs; anything else is flagged
    always_comb begin
        nibble = '0;
        blank  = (pattern == SEG_BLANK);
        bad    = 1'b0;
        case (pattern)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: bad    = !blank;
        endcase
    end

endmodule

// File: rtl/indicator_decoder.sv
// Receive side of the 4-digit multiplexed 7-segment bus. Synchronises the
// scanned bus, waits for each digit strobe to settle, decodes the glyph and
// reassembles the 16-bit displayed value with a per-frame pulse.
// Optional feature macro: INDICATOR_DECODER_RAW_EN adds the raw[31:0] port
// holding the normalised segment byte last captured for each digit.
module indicator_decoder
    import indicator_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES    = 4,
    parameter int unsigned DIGIT_ACTIVE_LOW = 1,
    parameter int unsigned SEG_ACTIVE_LOW   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  digits,
    input  logic [7:0]  segments,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        err
`ifdef INDICATOR_DECODER_RAW_EN
    ,
    output logic [31:0] raw
`endif
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end

    // Bus level seen when nothing is driven; also the synchroniser reset value
    localparam logic [3:0] DIG_IDLE      = {4{DIGIT_ACTIVE_LOW != 0}};
    localparam logic [7:0] SEG_IDLE      = {8{SEG_ACTIVE_LOW != 0}};
    localparam logic [7:0] SETTLE_TARGET = 8'(SETTLE_CYCLES);
    localparam bit         SETTLE_ONE    = (SETTLE_CYCLES == 1);

    logic [3:0] dig_s1, dig_s2;
    logic [7:0] seg_s1, seg_s2;

    logic [3:0] sel;
    logic [7:0] seg_n;
    logic [3:0] prev_sel;
    logic [7:0] prev_seg;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] cnt_inc;

    logic       sel_valid;
    logic       same;
    logic       restart;
    logic       capture;
    logic [1:0] idx;

    logic [3:0] dec_nibble;
    logic       dec_blank;
    logic       dec_bad;

    logic [3:0] seen;
    logic [3:0] seen_next;
    logic       seen_full;

    // Two-flop synchronisers for the asynchronous display bus
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_s1 <= DIG_IDLE;
            dig_s2 <= DIG_IDLE;
            seg_s1 <= SEG_IDLE;
            seg_s2 <= SEG_IDLE;
        end else begin
            dig_s1 <= digits;
            dig_s2 <= dig_s1;
            seg_s1 <= segments;
            seg_s2 <= seg_s1;
        end
    end

    // Normalise polarity, qualify the select and detect a stable bus
    always_comb begin
        sel       = dig_s2 ^ DIG_IDLE;
        seg_n     = seg_s2 ^ SEG_IDLE;
        sel_valid = $onehot(sel);
        same      = (sel == prev_sel) && (seg_n == prev_seg);
        idx       = onehot_index(sel);
        cnt_inc   = cnt + 8'd1;
        // A new (select, segments) pair starts a fresh settle count of 1
        restart   = sel_valid && ((state == WAIT) || !same);
        capture   = (restart && SETTLE_ONE) ||
                    (sel_valid && (state == SETTLE) && same && (cnt_inc == SETTLE_TARGET));
    end

    seg7_to_hex u_dec (
        .pattern (seg_n[BIT_G:BIT_A]),
        .nibble  (dec_nibble),
        .blank   (dec_blank),
        .bad     (dec_bad)
    );

    // Settle FSM: one capture per stable select period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT;
            cnt      <= '0;
            prev_sel <= '0;
            prev_seg <= '0;
        end else begin
            prev_sel <= sel;
            prev_seg <= seg_n;
            if (!sel_valid) begin
                state <= WAIT;
                cnt   <= '0;
            end else if (capture) begin
                state <= HOLD;
                cnt   <= SETTLE_TARGET;
            end else if (restart) begin
                state <= SETTLE;
                cnt   <= 8'd1;
            end else if (state == SETTLE) begin
                cnt   <= cnt_inc;
            end
        end
    end

    // Frame tracking: a full mask clears on the following cycle while still
    // accepting a capture landing on that same cycle
    always_comb begin
        seen_full = (seen == 4'b1111);
        seen_next = seen_full ? '0 : seen;
        if (capture && !dec_bad) begin
            seen_next = seen_next | sel;
        end
    end

    // Capture registers, frame pulse and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value       <= '0;
            dp          <= '0;
            blank       <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            seen        <= '0;
        end else begin
            frame_valid <= seen_full;
            seen        <= seen_next;
            if (capture) begin
                dp[idx]    <= seg_n[BIT_DP];
                blank[idx] <= dec_blank;
                if (dec_bad) begin
                    err <= 1'b1;
                end else begin
                    value[{idx, 2'b00} +: 4] <= dec_nibble;
                end
            end
        end
    end

`ifdef INDICATOR_DECODER_RAW_EN
    // Raw normalised byte per digit, written on every capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw <= '0;
        end else if (capture) begin
            raw[{idx, 3'b000} +: 8] <= seg_n;
        end
    end
`endif

endmodule

// File: tb/tb_indicator_decoder.sv
// Self-checking bench for indicator_decoder (active-low bus, SETTLE_CYCLES=4).
// Table of full scans plus hand-written reset, latency, glitch and
// async-reset sequences. Checks raw when INDICATOR_DECODER_RAW_EN is defined.
module tb_indicator_decoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  digits;
    logic [7:0]  segments;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        err;
`ifdef INDICATOR_DECODER_RAW_EN
    logic [31:0] raw;
`endif

    int total = 0;
    int bad   = 0;
    int frame_total = 0;

    indicator_decoder #(
        .SETTLE_CYCLES    (4),
        .DIGIT_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits      (digits),
        .segments    (segments),
        .value       (value),
        .dp          (dp),
        .blank       (blank),
        .frame_valid (frame_valid),
        .err         (err)
`ifdef INDICATOR_DECODER_RAW_EN
        ,
        .raw         (raw)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame pulses, sampled away from the active edge
    always @(negedge clk) begin
        if (frame_valid) frame_total++;
    end

    typedef struct {
        string       name;
        logic [31:0] pats;    // active-high byte for digit i at [8i+7:8i]
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        err;
        int          frames;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one digit on the bus for a number of cycles (called at negedge)
    task automatic show(input logic [1:0] d, input logic [7:0] pat, input int cycles);
        logic [3:0] oh;
        oh       = 4'b0001 << d;
        digits   = ~oh;
        segments = ~pat;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int f0;

        vecs[0] = '{"1234",  {8'h06, 8'h5B, 8'h4F, 8'h66}, 16'h1234, 4'b0000, 4'b0000, 1'b0, 1};
        vecs[1] = '{"5678dp", {8'h6D, 8'h7D, 8'h07, 8'hFF}, 16'h5678, 4'b0001, 4'b0000, 1'b0, 1};
        vecs[2] = '{"9AbC",  {8'h6F, 8'h77, 8'h7C, 8'h39}, 16'h9ABC, 4'b0000, 4'b0000, 1'b0, 1};
        vecs[3] = '{"dEF0",  {8'h5E, 8'h79, 8'h71, 8'h3F}, 16'hDEF0, 4'b0000, 4'b0000, 1'b0, 1};
        vecs[4] = '{"blank_dp", {8'h07, 8'h4F, 8'hF7, 8'h00}, 16'h73A0, 4'b0010, 4'b0001, 1'b0, 1};
        vecs[5] = '{"bad_d2", {8'h66, 8'h2A, 8'h5B, 8'h06}, 16'h4321, 4'b0000, 4'b0000, 1'b1, 0};
        vecs[6] = '{"5555",  {8'h6D, 8'h6D, 8'h6D, 8'h6D}, 16'h5555, 4'b0000, 4'b0000, 1'b1, 1};

        rst_n    = 1'b0;
        digits   = 4'hF;
        segments = 8'hFF;

        // Reset with a toggling bus
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            digits   = 4'($urandom);
            segments = 8'($urandom);
        end
        @(negedge clk);
        check("rst_value", 32'(value), 32'h0);
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_frame", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // Latency: digit 0 showing "1" is captured on the 6th edge after release
        digits   = 4'b1110;
        segments = ~8'h06;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("latency_early", 32'(value), 32'h0);
        @(negedge clk);
        check("latency_capture", 32'(value), 32'h0001);

        // Select glitches: 2-cycle strobes and a double select never capture
        f0 = frame_total;
        show(2'd0, 8'h07, 2);
        show(2'd1, 8'h7F, 2);
        digits   = 4'b1100;
        segments = ~8'h6F;
        repeat (20) @(negedge clk);
        digits = 4'b1111;
        repeat (5) @(negedge clk);
        check("glitch_value", 32'(value), 32'h0001);
        check("glitch_frames", 32'(frame_total - f0), 32'h0);

        // Table of full scans, digit 0 first
        for (int v = 0; v < 7; v++) begin
            f0 = frame_total;
            for (int d = 0; d < 4; d++) begin
                logic [31:0] p;
                p = vecs[v].pats;
                show(2'(d), p[8*d +: 8], 20);
            end
            check({vecs[v].name, "_value"}, 32'(value), 32'(vecs[v].value));
            check({vecs[v].name, "_dp"}, 32'(dp), 32'(vecs[v].dp));
            check({vecs[v].name, "_blank"}, 32'(blank), 32'(vecs[v].blank));
            check({vecs[v].name, "_err"}, 32'(err), 32'(vecs[v].err));
            check({vecs[v].name, "_frames"}, 32'(frame_total - f0), 32'(vecs[v].frames));
`ifdef INDICATOR_DECODER_RAW_EN
            check({vecs[v].name, "_raw"}, raw, vecs[v].pats);
`endif
        end

        // Async reset in the middle of a settle window
        digits   = 4'b1110;
        segments = ~8'h7F;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_value", 32'(value), 32'h0);
        check("areset_err", 32'(err), 32'h0);
        check("areset_dp", 32'(dp), 32'h0);
        check("areset_blank", 32'(blank), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // A fresh full scan is needed before the next frame pulse
        f0 = frame_total;
        show(2'd0, 8'h79, 20);
        show(2'd1, 8'h71, 20);
        show(2'd2, 8'h77, 20);
        check("after_rst_partial_frames", 32'(frame_total - f0), 32'h0);
        show(2'd3, 8'h39, 20);
        check("after_rst_full_frames", 32'(frame_total - f0), 32'h1);
        check("after_rst_value", 32'(value), 32'hCAFE);
`ifdef INDICATOR_DECODER_RAW_EN
        check("after_rst_raw", raw, 32'h39777179);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
